aes_bus_mux: RTL
================

# aes_bus_mux

Parametrised, registered bus-select stage for the AES datapath. It generalises the fixed four-source bus B selector to NUM_SRC sources of DATA_W bits, with per-source zero-extension of narrow operands. Each selected word passes through a valid/ready handshake and a 2-entry output buffer, so the round-key and state registers can feed a stalling consumer, such as the S-box or MixColumns stage, without dropping operands.

## Interface
Parameters:
- NUM_SRC, 4, number of source registers (2..16)
- DATA_W, 128, bus width in bits
- NARROW_W, 64, width of narrow sources (1..DATA_W)
- NARROW_MASK, 4'b1000, bit i set = source i is narrow (NUM_SRC bits wide)
- SEL_W, $clog2(NUM_SRC), select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- src  in  NUM_SRC x DATA_W  packed source array; src[i] is source i
- sel  in  SEL_W  source select, sampled with in_valid
- in_valid  in  1  request to transfer the selected source
- in_ready  out  1  stage can accept
- bus_data  out  DATA_W  buffered selected word
- bus_sel  out  SEL_W  select that produced bus_data
- out_valid  out  1  bus_data valid
- out_ready  in  1  consumer accepts
- sel_err  out  1  present only with AES_BUS_MUX_SELERR_EN; see Configuration

## Operation
- Transfer in: occurs when in_valid && in_ready. The word {src[sel] masked} and sel are written into a 2-entry FIFO.
- Masking: if NARROW_MASK[sel] is set, bits DATA_W-1..NARROW_W are forced to 0 and bits NARROW_W-1..0 are taken from src[sel]. Otherwise the full word is taken.
- Out-of-range select (sel >= NUM_SRC; possible only when NUM_SRC is not a power of 2): the stored word is all-zero and bus_sel stores sel unchanged.
- Transfer out: occurs when out_valid && out_ready. The head entry is popped.
- Occupancy count is 0..2:
  - in_ready = (count < 2)
  - out_valid = (count != 0)
- Simultaneous push and pop:
  - count 1: count stays 1, the new entry becomes head on the next cycle.
  - count 0: push only; the pop is invalid because out_valid = 0.
  - count 2: pop only; no push because in_ready = 0.
- Order is strictly FIFO. No reordering and no bypass.
- src is not required to be stable after the accepting edge; only the captured value is used.

## Timing
- Latency: 1 cycle. A word accepted at edge N appears on bus_data with out_valid = 1 after edge N, if the buffer was empty.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready depends on registered count only; there is no combinational path from out_ready.
- bus_data and bus_sel are driven from the head storage register. They stay stable while out_valid && !out_ready.
- Reset (rst_n low, asynchronous):
  - count = 0, so out_valid = 0 and in_ready = 1
  - bus_data = 0, bus_sel = 0, sel_err = 0
  - both buffer entries = 0
- Reset mid-operation discards buffered words. The first post-reset transfer is accepted on the first rising edge with rst_n high.

## Configuration
- Macro: AES_BUS_MUX_SELERR_EN.
- Defined:
  - Port sel_err exists and travels with each entry as a 1-bit flag.
  - sel_err = 1 alongside out_valid when the head entry was captured with sel >= NUM_SRC; it is 0 otherwise.
  - Data is still zeroed for such entries.
- Undefined:
  - Port sel_err is absent. Out-of-range entries produce zero data silently.
- All other behaviour is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W = 128 and AES_HALF_W = 64 constants, the defaults for DATA_W and NARROW_W
  - typedef aes_word_t (logic [AES_BLOCK_W-1:0])
- Sub-module aes_skid_fifo2: a generic 2-entry valid/ready FIFO parametrised by payload width, with payload {sel_err?, sel, data}. aes_bus_mux instantiates it behind the combinational select/mask logic.

## Test plan
- Reset, then NUM_SRC=4 defaults: src[1]=128'hA5…A5, sel=1, in_valid for one cycle with out_ready=1 -> bus_data=128'hA5…A5 and bus_sel=1 on the next cycle, out_valid for exactly 1 cycle.
- Narrow source: src[3]=128'hFFFF…FFFF, sel=3 -> bus_data=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Backpressure: out_ready=0, push words for sel 0,1,2 on consecutive cycles -> first two accepted, in_ready=0 at third; raise out_ready -> words for sel 0 then 1 appear in order, third accepted after the first pop.
- Streaming: out_ready=1, in_valid=1 for 8 cycles cycling sel 0..3 -> 8 outputs in order, in_ready never drops.
- NUM_SRC=3, macro defined, sel=3 -> bus_data=0, bus_sel=3, sel_err=1. Without the macro -> bus_data=0 and no sel_err port.
- Assert rst_n low with 2 entries buffered and out_ready=0 -> out_valid=0, bus_data=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: constants and types shared across the AES datapath.
//   AES_BLOCK_W : width of one AES state / round-key block
//   AES_HALF_W  : width of a half block (narrow operands)
//   aes_word_t  : one full AES block word
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_HALF_W  = 64;

    typedef logic [AES_BLOCK_W-1:0] aes_word_t;

endpackage : aes_pkg

// File: rtl/aes_skid_fifo2.sv
// aes_skid_fifo2: generic 2-entry valid/ready FIFO.
// The head entry is always held in head_q, so out_data comes straight from a
// register and stays stable while the consumer stalls.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   producer handshake (in_ready from registered count only)
//   in_data               payload pushed on in_valid && in_ready
//   out_valid / out_ready consumer handshake
//   out_data              head payload
module aes_skid_fifo2 #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic [1:0]           count_q, count_d;
    logic [PAYLOAD_W-1:0] head_q, head_d;
    logic [PAYLOAD_W-1:0] tail_q, tail_d;
    logic                 push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        if (push && pop) begin
            // Only reachable with one entry: the new word replaces the head.
            head_d = in_data;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
            count_d = count_q + 2'd1;
        end else if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule : aes_skid_fifo2

// File: rtl/aes_bus_mux.sv
// aes_bus_mux: registered NUM_SRC-way bus select for the AES datapath.
// Selects src[sel], zero-extends narrow sources (NARROW_MASK), and buffers the
// word plus its select in a 2-entry valid/ready FIFO.
// Optional feature macro: AES_BUS_MUX_SELERR_EN adds the sel_err output, flagging
// entries captured with an out-of-range select.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   src                   packed source array, src[i] is source i
//   sel, in_valid         select and transfer request; in_ready = space available
//   bus_data, bus_sel     buffered word and the select that produced it
//   out_valid, out_ready  output handshake
//   sel_err               (macro only) head entry had sel >= NUM_SRC
module aes_bus_mux
    import aes_pkg::*;
#(
    parameter int                 NUM_SRC     = 4,
    parameter int                 DATA_W      = AES_BLOCK_W,
    parameter int                 NARROW_W    = AES_HALF_W,
    parameter logic [NUM_SRC-1:0] NARROW_MASK = 4'b1000,
    parameter int                 SEL_W       = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] src,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_W-1:0]              bus_data,
    output logic [SEL_W-1:0]               bus_sel,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef AES_BUS_MUX_SELERR_EN
    ,
    output logic                           sel_err
`endif
);

    // Keeps bits NARROW_W-1..0; a shift keeps this legal when NARROW_W == DATA_W.
    localparam logic [DATA_W-1:0] NARROW_KEEP = {DATA_W{1'b1}} >> (DATA_W - NARROW_W);

`ifdef AES_BUS_MUX_SELERR_EN
    localparam int PAYLOAD_W = 1 + SEL_W + DATA_W;
`else
    localparam int PAYLOAD_W = SEL_W + DATA_W;
`endif

    logic [DATA_W-1:0]    word_sel;
    logic [DATA_W-1:0]    word_masked;
    logic                 narrow;
    logic                 in_range;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Compare against each legal index so an out-of-range select never indexes
    // past the source array; it simply leaves the word at zero.
    always_comb begin
        word_sel = '0;
        narrow   = 1'b0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                word_sel = src[i];
                narrow   = NARROW_MASK[i];
                in_range = 1'b1;
            end
        end
        word_masked = narrow ? (word_sel & NARROW_KEEP) : word_sel;
    end

`ifdef AES_BUS_MUX_SELERR_EN
    assign in_payload = {~in_range, sel, word_masked};
    assign sel_err    = out_valid & out_payload[PAYLOAD_W-1];
`else
    assign in_payload = {sel, word_masked};
`endif

    aes_skid_fifo2 #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign bus_data = out_payload[DATA_W-1:0];
    assign bus_sel  = out_payload[DATA_W +: SEL_W];

endmodule : aes_bus_mux
